// File: rtl/hazard_detect_unit_pkg.sv
// hazard_detect_unit_pkg
// Shared types for the hazard detection unit: instruction class encodings,
// forward-select constants, tracked slot payloads and the slot/operand
// match helper used by the top.
package hazard_detect_unit_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    typedef enum logic [1:0] {
        HZ_NONE  = 2'd0,
        HZ_ALU   = 2'd1,
        HZ_LOAD  = 2'd2,
        HZ_STORE = 2'd3
    } hz_optype_e;

    localparam logic [FWD_W-1:0] FWD_REGFILE  = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EX_ALU   = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEM_ALU  = 2'd2;
    localparam logic [FWD_W-1:0] FWD_MEM_LOAD = 2'd3;

    // EX keeps rs2 so a store's data operand can be matched against MEM.
    typedef struct packed {
        hz_optype_e        optype;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs2;
    } ex_slot_t;

    typedef struct packed {
        hz_optype_e        optype;
        logic [REG_AW-1:0] rd;
    } mw_slot_t;

    // A slot produces an ID operand only if that operand is really read,
    // is not x0, and the slot writes rd from the ALU or from a load.
    function automatic logic slot_hit(input logic              use_rs,
                                      input logic [REG_AW-1:0] rs,
                                      input hz_optype_e        optype,
                                      input logic [REG_AW-1:0] rd);
        return use_rs && (rs != '0) && (rd == rs) &&
               ((optype == HZ_ALU) || (optype == HZ_LOAD));
    endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// hazard_slot_pipe
// EX/MEM/WB shadow registers of the instructions in flight.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears all slots)
//   bubble    - load an empty slot into EX instead of the ID instruction
//   id_slot   - {optype, rd, rs2} of the instruction leaving ID
//   ex_slot, mem_slot, wb_slot - current slot contents
module hazard_slot_pipe
    import hazard_detect_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     bubble,
    input  ex_slot_t id_slot,
    output ex_slot_t ex_slot,
    output mw_slot_t mem_slot,
    output mw_slot_t wb_slot
);

    localparam ex_slot_t EX_EMPTY = '{optype: HZ_NONE, rd: '0, rs2: '0};
    localparam mw_slot_t MW_EMPTY = '{optype: HZ_NONE, rd: '0};

    ex_slot_t ex_d,  ex_q;
    mw_slot_t mem_d, mem_q;
    mw_slot_t wb_d,  wb_q;

    // Advance the slots; a bubble replaces the ID instruction entering EX.
    always_comb begin
        ex_d  = id_slot;
        mem_d = '{optype: ex_q.optype, rd: ex_q.rd};
        wb_d  = mem_q;
        if (bubble) begin
            ex_d = EX_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= EX_EMPTY;
            mem_q <= MW_EMPTY;
            wb_q  <= MW_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_slot  = ex_q;
    assign mem_slot = mem_q;
    assign wb_slot  = wb_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit
// Data-hazard detection for a 5-stage pipeline: forwarding selects for the
// ID operands and store data, load-use stall and branch flush control.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding on). Without it all
// selects are 0 and any EX/MEM producer of an ID operand stalls.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   rs1_id, rs2_id, rd_id         - register fields of the ID instruction
//   rs1use_id, rs2use_id          - operand-used flags
//   hazard_optype_id              - ID class: NONE/ALU/LOAD/STORE
//   branch_id                     - redirect taken in ID
//   forward_ctrl_A/B              - ID operand source select
//   forward_ctrl_ls               - store-data source for the store in EX
//   PC_EN_IF, reg_FD_EN           - PC and IF/ID write enables
//   reg_FD_flush, reg_DE_flush    - bubble into IF/ID and ID/EX
// All outputs are combinational from the slots and ID inputs.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              rs1use_id,
    input  logic              rs2use_id,
    input  logic [1:0]        hazard_optype_id,
    input  logic              branch_id,
    output logic [FWD_W-1:0]  forward_ctrl_A,
    output logic [FWD_W-1:0]  forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush
);

    hz_optype_e id_optype_c;
    ex_slot_t   id_slot_c;
    ex_slot_t   ex_slot;
    mw_slot_t   mem_slot;
    mw_slot_t   wb_slot;
    logic       stall_c;
    logic       ex_hit1_c, ex_hit2_c, mem_hit1_c, mem_hit2_c;
    logic       unused_c;

    assign id_optype_c = hz_optype_e'(hazard_optype_id);
    assign id_slot_c   = '{optype: id_optype_c, rd: rd_id, rs2: rs2_id};

    hazard_slot_pipe u_slot_pipe (
        .clk      (clk),
        .rst      (rst),
        .bubble   (stall_c),
        .id_slot  (id_slot_c),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot)
    );

    // WB is tracked for visibility only: the regfile writes before it is read.
    assign unused_c = ^{wb_slot, ex_slot.rs2};

    // EX ALU result is newest, so it wins over anything in MEM.
    function automatic logic [FWD_W-1:0] fwd_sel(input logic       ex_hit,
                                                 input hz_optype_e ex_op,
                                                 input logic       mem_hit,
                                                 input hz_optype_e mem_op);
        if (ex_hit && (ex_op == HZ_ALU))         return FWD_EX_ALU;
        else if (mem_hit && (mem_op == HZ_ALU))  return FWD_MEM_ALU;
        else if (mem_hit && (mem_op == HZ_LOAD)) return FWD_MEM_LOAD;
        else                                     return FWD_REGFILE;
    endfunction

    // Operand matches, stall and forward selection.
    always_comb begin
        ex_hit1_c       = slot_hit(rs1use_id, rs1_id, ex_slot.optype, ex_slot.rd);
        ex_hit2_c       = slot_hit(rs2use_id, rs2_id, ex_slot.optype, ex_slot.rd);
        mem_hit1_c      = slot_hit(rs1use_id, rs1_id, mem_slot.optype, mem_slot.rd);
        mem_hit2_c      = slot_hit(rs2use_id, rs2_id, mem_slot.optype, mem_slot.rd);
        stall_c         = 1'b0;
        forward_ctrl_A  = FWD_REGFILE;
        forward_ctrl_B  = FWD_REGFILE;
        forward_ctrl_ls = 1'b0;
`ifdef HAZARD_FORWARD_EN
        // A store's data operand can wait one cycle for MEM load data.
        stall_c = (ex_slot.optype == HZ_LOAD) &&
                  (ex_hit1_c || (ex_hit2_c && (id_optype_c != HZ_STORE)));
        forward_ctrl_A  = fwd_sel(ex_hit1_c, ex_slot.optype, mem_hit1_c, mem_slot.optype);
        forward_ctrl_B  = fwd_sel(ex_hit2_c, ex_slot.optype, mem_hit2_c, mem_slot.optype);
        forward_ctrl_ls = (ex_slot.optype == HZ_STORE) && (mem_slot.optype == HZ_LOAD) &&
                          (mem_slot.rd == ex_slot.rs2) && (mem_slot.rd != '0);
`else
        stall_c = ex_hit1_c || ex_hit2_c || mem_hit1_c || mem_hit2_c;
`endif
    end

    // Pipeline control; a redirect is held off until its operands resolve.
    always_comb begin
        PC_EN_IF     = ~stall_c;
        reg_FD_EN    = ~stall_c;
        reg_DE_flush = stall_c;
        reg_FD_flush = branch_id & ~stall_c;
    end

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       rs1use_id, rs2use_id;
    logic [1:0] hazard_optype_id;
    logic       branch_id;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;
    logic       forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;

    int checks   = 0;
    int failures = 0;

    // Reference model: the last three issued instructions, index 0 = EX.
    typedef struct {
        int op;
        int rd;
        int rs2;
    } ins_t;
    ins_t hist[3];

    hazard_detect_unit dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_id           (rs1_id),
        .rs2_id           (rs2_id),
        .rd_id            (rd_id),
        .rs1use_id        (rs1use_id),
        .rs2use_id        (rs2use_id),
        .hazard_optype_id (hazard_optype_id),
        .branch_id        (branch_id),
        .forward_ctrl_A   (forward_ctrl_A),
        .forward_ctrl_B   (forward_ctrl_B),
        .forward_ctrl_ls  (forward_ctrl_ls),
        .PC_EN_IF         (PC_EN_IF),
        .reg_FD_EN        (reg_FD_EN),
        .reg_FD_flush     (reg_FD_flush),
        .reg_DE_flush     (reg_DE_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Does in-flight instruction e produce register rs read by ID?
    function automatic bit produces(input ins_t e, input bit used, input int rs);
        return used && rs != 0 && e.rd == rs && (e.op == 1 || e.op == 2);
    endfunction

    function automatic int src_of(input bit used, input int rs);
        if (produces(hist[0], used, rs) && hist[0].op == 1) return 1;
        if (produces(hist[1], used, rs) && hist[1].op == 1) return 2;
        if (produces(hist[1], used, rs) && hist[1].op == 2) return 3;
        return 0;
    endfunction

    // One cycle: drive ID, compare against the model, then advance the model.
    task automatic step(input bit r, input int a, input int b, input int d,
                        input bit ua, input bit ub, input int op, input bit br);
        bit stall;
        int ea, eb;
        bit els;
        @(negedge clk);
        rst = r; rs1_id = 5'(a); rs2_id = 5'(b); rd_id = 5'(d);
        rs1use_id = ua; rs2use_id = ub; hazard_optype_id = 2'(op); branch_id = br;
        #1;
`ifdef HAZARD_FORWARD_EN
        stall = hist[0].op == 2 &&
                (produces(hist[0], ua, a) || (produces(hist[0], ub, b) && op != 3));
        ea = src_of(ua, a);
        eb = src_of(ub, b);
        els = hist[0].op == 3 && hist[1].op == 2 && hist[1].rd == hist[0].rs2 && hist[1].rd != 0;
`else
        stall = 0;
        for (int k = 0; k < 2; k++)
            if (produces(hist[k], ua, a) || produces(hist[k], ub, b)) stall = 1;
        ea = 0; eb = 0; els = 0;
`endif
        chk("fwd_A",     forward_ctrl_A,  2'(ea));
        chk("fwd_B",     forward_ctrl_B,  2'(eb));
        chk("fwd_ls",    forward_ctrl_ls, 2'(els));
        chk("pc_en",     PC_EN_IF,        2'(!stall));
        chk("fd_en",     reg_FD_EN,       2'(!stall));
        chk("de_flush",  reg_DE_flush,    2'(stall));
        chk("fd_flush",  reg_FD_flush,    2'(br && !stall));
        if (r) begin
            for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = stall ? '{0, 0, 0} : '{op, d, b};
        end
    endtask

    initial begin
        rst = 1'b1; rs1_id = '0; rs2_id = '0; rd_id = '0;
        rs1use_id = 1'b0; rs2use_id = 1'b0; hazard_optype_id = '0; branch_id = 1'b0;
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
        repeat (2) @(posedge clk);

        // Reset state with a redirect in ID.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_fd_flush", reg_FD_flush, 2'd1);
        chk("rst_pc_en", PC_EN_IF, 2'd1);

`ifdef HAZARD_FORWARD_EN
        // add x5 in EX, add x6,x5,x1 in ID.
        step(0, 0, 0, 5, 0, 0, 1, 0);
        step(0, 5, 1, 6, 1, 1, 1, 0);
        chk("alu_fwd_A", forward_ctrl_A, 2'd1);
        chk("alu_nostall", PC_EN_IF, 2'd1);
        // lw x5 then a use: one stall, then MEM load data.
        step(0, 0, 0, 5, 0, 0, 2, 0);
        step(0, 5, 1, 6, 1, 1, 1, 0);
        chk("lu_pc_en", PC_EN_IF, 2'd0);
        chk("lu_de_flush", reg_DE_flush, 2'd1);
        step(0, 5, 1, 6, 1, 1, 1, 0);
        chk("lu_fwd_A", forward_ctrl_A, 2'd3);
        // lw x5 then sw x5,0(x2): no stall, store data from MEM load.
        step(0, 0, 0, 5, 0, 0, 2, 0);
        step(0, 2, 5, 0, 1, 1, 3, 0);
        chk("ls_nostall", PC_EN_IF, 2'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ls_fwd", forward_ctrl_ls, 2'd1);
        // add x5 in MEM and EX, ID reads x5 as rs2: EX wins.
        step(0, 0, 0, 5, 0, 0, 1, 0);
        step(0, 0, 0, 5, 0, 0, 1, 0);
        step(0, 0, 5, 7, 0, 1, 1, 0);
        chk("prio_fwd_B", forward_ctrl_B, 2'd1);
        // x0 is never forwarded.
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 7, 1, 1, 1, 0);
        chk("x0_fwd_A", forward_ctrl_A, 2'd0);
        chk("x0_fwd_B", forward_ctrl_B, 2'd0);
        // Branch on a loaded register waits out the stall.
        step(0, 0, 0, 5, 0, 0, 2, 0);
        step(0, 5, 0, 0, 1, 0, 0, 1);
        chk("br_fd_flush_stall", reg_FD_flush, 2'd0);
        step(0, 5, 0, 0, 1, 0, 0, 1);
        chk("br_fd_flush_after", reg_FD_flush, 2'd1);
`else
        // add x5 then add x6,x5,x0: two stall cycles, no forwarding.
        step(0, 0, 0, 5, 0, 0, 1, 0);
        step(0, 5, 0, 6, 1, 1, 1, 0);
        chk("nf_stall1", PC_EN_IF, 2'd0);
        chk("nf_sel1", forward_ctrl_A, 2'd0);
        step(0, 5, 0, 6, 1, 1, 1, 0);
        chk("nf_stall2", PC_EN_IF, 2'd0);
        step(0, 5, 0, 6, 1, 1, 1, 0);
        chk("nf_release", PC_EN_IF, 2'd1);
        // Store data operand stalls too.
        step(0, 0, 0, 9, 0, 0, 1, 0);
        step(0, 2, 9, 0, 1, 1, 3, 0);
        chk("nf_store_stall", reg_DE_flush, 2'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`endif

        // Reset in the middle of a load-use stall.
        step(0, 0, 0, 5, 0, 0, 2, 0);
        step(0, 5, 1, 6, 1, 1, 1, 0);
        chk("rst_mid_stall_before", PC_EN_IF, 2'd0);
        step(1, 5, 1, 6, 1, 1, 1, 0);
        step(0, 5, 1, 6, 1, 1, 1, 0);
        chk("rst_mid_stall_after", PC_EN_IF, 2'd1);
        chk("rst_mid_stall_fwd", forward_ctrl_A, 2'd0);

        // Random traffic on a small register window to force collisions.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rs1_id, rs2_id, rd_id  input  5 each  register fields of the instruction in ID.
REQ-005 rs1use_id, rs2use_id  input  1 each  operand-used flags from the decode control logic.
REQ-006 hazard_optype_id  input  2  ID instruction class: 0 NONE, 1 ALU (writes rd from ALU), 2 LOAD, 3 STORE.
REQ-007 branch_id  input  1  redirect taken in ID (taken branch, JAL, JALR).
REQ-008 forward_ctrl_A, forward_ctrl_B  output  2 each  ID operand source: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data.
REQ-009 forward_ctrl_ls  output  1  store-data source for the store in EX: 0 forwarded rs2, 1 MEM load data.
REQ-010 PC_EN_IF, reg_FD_EN  output  1 each  PC and IF/ID register write enables.
REQ-011 reg_FD_flush, reg_DE_flush  output  1 each  bubble insert into IF/ID and ID/EX.

Function
REQ-012 Internal slots SHALL track {optype, rd, rs2} for EX and {optype, rd} for MEM and WB.
REQ-013 Each edge: MEM<=EX, WB<=MEM; EX<=ID fields unless stall or reg_DE_flush, then EX<={NONE, 0, 0}.
REQ-014 A slot SHALL match operand rsN only if rsNuse_id=1, rsN!=0, rd==rsN and optype is ALU or LOAD.
REQ-015 load_use stall SHALL assert when EX slot is LOAD and matches rs1, or matches rs2 and ID optype is not STORE.
REQ-016 Stall SHALL drive PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1, reg_FD_flush=0; otherwise PC_EN_IF=1, reg_FD_EN=1.
REQ-017 reg_FD_flush SHALL equal branch_id & ~stall; a redirect with an unresolved operand waits until the stall clears.
REQ-018 Forward select: EX ALU match -> 1; else MEM ALU match -> 2; else MEM LOAD match -> 3; else 0 (EX wins over MEM).
REQ-019 forward_ctrl_ls SHALL be 1 iff EX slot is STORE, MEM slot is LOAD, MEM rd==EX rs2, rd!=0.
REQ-020 All outputs SHALL be combinational from slots and ID inputs; zero latency.

Reset
REQ-021 While rst=1 all slots SHALL load {NONE, 0, 0} on the edge.
REQ-022 With cleared slots: forward_ctrl_*=0, PC_EN_IF=1, reg_FD_EN=1, reg_DE_flush=0, reg_FD_flush=branch_id.
REQ-023 Reset mid-stall SHALL clear the stall on the following cycle; no stale forward selects.

Configuration
REQ-024 Macro HAZARD_FORWARD_EN defined: behaviour per REQ-015..REQ-019.
REQ-025 HAZARD_FORWARD_EN undefined: forward_ctrl_* tied 0; stall whenever EX or MEM slot matches rs1 or rs2 (STORE rs2 included); WB needs no stall (regfile write-before-read).

Structure
REQ-026 Shared package SHALL hold optype encodings (HZ_NONE/ALU/LOAD/STORE) and forward-select constants.
REQ-027 One sub-module hazard_slot_pipe (EX/MEM/WB slot registers with bubble insert); match/priority logic stays in the top.

Verification
REQ-028 add x5 in EX, ID add x6,x5,x1 -> forward_ctrl_A=1, no stall.
REQ-029 lw x5 in EX, ID add x6,x5,x1 -> one cycle PC_EN_IF=0, reg_DE_flush=1; next cycle forward_ctrl_A=3.
REQ-030 lw x5 in EX, ID sw x5,0(x2) -> no stall; next cycle forward_ctrl_ls=1.
REQ-031 add x5 in EX and add x5 in MEM, ID uses x5 as rs2 -> forward_ctrl_B=1; rd=x0 everywhere -> all selects 0.
REQ-032 branch_id=1 with load-use on rs1 -> reg_FD_flush=0 during stall, 1 next cycle.
REQ-033 Without HAZARD_FORWARD_EN, add x5 then add x6,x5,x0 -> two stall cycles, selects 0; rst mid-stall -> stall drops next cycle.
